// File: rtl/ac_motor_ramp_ctrl_if.sv
// Setpoint/control bundle between the soft-start sequencer and its controller.
// The sequencer attaches through the slave modport. The driving side attaches through the master modport.
interface ac_motor_ramp_ctrl_if;
    localparam int unsigned FW = 12;
    localparam int unsigned SW = 3;

    logic          lock;
    logic          start;
    logic          stop;
    logic          fault;
    logic [FW-1:0] target_freq;
    logic [FW-1:0] frequency;
    logic [FW-1:0] amplitude;
    logic          pwm_en;
    logic          busy;
    logic [SW-1:0] state;

    modport master (
        output lock, start, stop, fault, target_freq,
        input  frequency, amplitude, pwm_en, busy, state
    );

    modport slave (
        input  lock, start, stop, fault, target_freq,
        output frequency, amplitude, pwm_en, busy, state
    );
endinterface

// File: rtl/ac_motor_ramp_ctrl.sv
// Soft-start sequencer for the sine PWM path.
// Ramps frequency toward the target on carrier-aligned ticks, follows a V/f amplitude law, and sequences run/stop/fault.
module ac_motor_ramp_ctrl #(
    parameter int unsigned STEP_DIV = 16,
    parameter int unsigned F_STEP   = 8,
    parameter int unsigned AMP_MIN  = 256,
    parameter int unsigned KVF      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ac_motor_ramp_ctrl_if.slave   bus
);
    localparam int unsigned FW = 12;
    localparam int unsigned CW = 10;
    localparam int unsigned PW = 24;
    localparam logic [PW-1:0] AMP_SAT = PW'(4095);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP      = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] freq_q, freq_d;
    logic [FW-1:0] amp_q, amp_d;
    logic          pwm_q, pwm_d;
    logic          busy_q, busy_d;

    logic          tick_c;
    logic          up_c;
    logic [FW-1:0] diff_c;
    logic [FW-1:0] step_c;
    logic [PW-1:0] prod_c;
    logic [PW-1:0] amp_wide_c;

    assign tick_c = bus.lock && (cnt_q == CW'(STEP_DIV - 1));
    assign up_c   = (bus.target_freq >= freq_q);
    // Distance still to cover; ramp-down always heads for zero.
    assign diff_c = (state_q == RAMP_DOWN) ? freq_q
                  : (up_c ? (bus.target_freq - freq_q) : (freq_q - bus.target_freq));
    assign step_c = (diff_c > FW'(F_STEP)) ? FW'(F_STEP) : diff_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            freq_q  <= '0;
            amp_q   <= '0;
            pwm_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            amp_q   <= amp_d;
            pwm_q   <= pwm_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        amp_d      = '0;
        pwm_d      = 1'b0;
        busy_d     = 1'b0;
        cnt_d      = cnt_q;
        prod_c     = '0;
        amp_wide_c = '0;

        if (bus.fault) begin
            state_d = FAULT;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start && !bus.stop) state_d = RAMP;
                RAMP: begin
                    if (bus.stop) begin
                        state_d = RAMP_DOWN;
                    end else if (tick_c) begin
                        freq_d = up_c ? (freq_q + step_c) : (freq_q - step_c);
                        if (freq_d == bus.target_freq) state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.stop)                            state_d = RAMP_DOWN;
                    else if (bus.target_freq != freq_q)      state_d = RAMP;
                end
                RAMP_DOWN: begin
                    if (bus.start && !bus.stop) begin
                        state_d = RAMP;
                    end else if (tick_c) begin
                        freq_d = freq_q - step_c;
                        if (freq_d == '0) state_d = IDLE;
                    end
                end
                FAULT: if (bus.stop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Amplitude is derived from the frequency being registered, keeping the pair coherent.
        if (state_d == IDLE || state_d == FAULT) begin
            freq_d = '0;
        end else begin
            pwm_d      = 1'b1;
            prod_c     = PW'(freq_d) * PW'(KVF);
            amp_wide_c = PW'(AMP_MIN) + (prod_c >> 5);
            amp_d      = (amp_wide_c > AMP_SAT) ? FW'(4095) : amp_wide_c[FW-1:0];
        end
        busy_d = (state_d == RAMP) || (state_d == RAMP_DOWN);

        // A lock coinciding with a state change is dropped along with the count.
        if (state_d != state_q)  cnt_d = '0;
        else if (bus.lock)       cnt_d = tick_c ? '0 : cnt_q + CW'(1);
    end

    assign bus.frequency = freq_q;
    assign bus.amplitude = amp_q;
    assign bus.pwm_en    = pwm_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;
endmodule

// File: doc/ac_motor_ramp_ctrl.md
# ac_motor_ramp_ctrl

Soft-start sequencer for the three-phase sine PWM path. It drives the sine generator's `frequency` and `amplitude` inputs from a requested target. Frequency ramps at a programmable rate, and amplitude follows a volts-per-hertz law with low-speed boost. All setpoint updates are aligned to the carrier `lock` pulse. The block also owns run/stop/fault sequencing and gates the comparator outputs through `pwm_en`.

## Interface
Parameters:
- `STEP_DIV`, default 16: lock pulses per ramp step (1..1023).
- `F_STEP`, default 8: maximum frequency change per ramp step (1..4095).
- `AMP_MIN`, default 256: boost amplitude at zero frequency.
- `KVF`, default 32: V/f slope. `amplitude = AMP_MIN + ((freq*KVF) >> 5)`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `lock`  in  1  one-cycle pulse per carrier period, from the triangle generator.
- `start`  in  1  level; request run.
- `stop`  in  1  level; request controlled stop; also clears a latched fault.
- `fault`  in  1  level; immediate shutdown.
- `target_freq`  in  12  requested frequency word (unsigned).
- `frequency`  out  12  to the sine generator.
- `amplitude`  out  12  to the sine generator.
- `pwm_en`  out  1  enables the comparator/dead-time outputs.
- `busy`  out  1  high in RAMP or RAMP_DOWN.
- `state`  out  3  IDLE=0, RAMP=1, RUN=2, RAMP_DOWN=3, FAULT=4.

## Operation
- Reset values: `state`=IDLE, `frequency`=0, `amplitude`=0, `pwm_en`=0, `busy`=0, step counter=0.
- Step tick: the counter increments on each `lock`. The tick fires on the `lock` where the count is STEP_DIV-1; the counter then wraps to 0. The counter is cleared on every state change.
- Amplitude:
  - Computed from the new frequency with a 24-bit intermediate.
  - Saturates at 4095.
  - Registered in the same edge as `frequency`, so the pair never mismatches.
  - Forced to 0 in IDLE and FAULT.
- Priority, evaluated every cycle: `fault` > `stop` > `start`.
- IDLE:
  - `start`&!`stop`&!`fault` -> RAMP.
  - `pwm_en`<=1, `frequency`=0, `amplitude`<=AMP_MIN.
- RAMP (tracks in either direction):
  - On each tick, frequency moves toward `target_freq` by min(F_STEP, |target-freq|).
  - When the updated frequency equals target, go to RUN in the same edge.
  - `stop` -> RAMP_DOWN.
- RUN:
  - `target_freq` != `frequency` -> RAMP.
  - `stop` -> RAMP_DOWN.
- RAMP_DOWN:
  - On each tick, frequency decreases by min(F_STEP, freq).
  - On the edge where it reaches 0: -> IDLE, `pwm_en`<=0, `amplitude`<=0.
  - `start`&!`stop` -> RAMP, which resumes from the current frequency.
  - If frequency is already 0 on entry, return to IDLE on the first tick.
- FAULT, entered from any state:
  - On the next edge: `pwm_en`<=0, `frequency`<=0, `amplitude`<=0.
  - Remains latched while `fault`=1.
  - Exit to IDLE only when `fault`=0 and `stop`=1. `start` is ignored.
- Arithmetic: unsigned 12-bit frequency, no wrap-around; all steps are clamped at target or 0.
- `target_freq`=0 in IDLE with `start`: -> RAMP, then RUN on the first tick at frequency 0 with `pwm_en`=1.

## Timing
- All outputs are registered and change only on the `clk` rising edge.
- Frequency and amplitude change only in the cycle after a tick `lock`, i.e. at a carrier-period boundary.
- State changes caused by `start`, `stop` or `fault` take effect on the first edge after assertion (1-cycle latency), independent of `lock`.
- `fault` to `pwm_en`=0: exactly 1 clock.
- Full ramp 0 -> T takes ceil(T/F_STEP) ticks = ceil(T/F_STEP)*STEP_DIV lock pulses.
- `lock` coincident with a state change: the counter clears and the pulse is not counted.
- `rst_n` low mid-ramp: all outputs go to reset values immediately (asynchronous). On release, the block restarts in IDLE and requires a new `start`.

## Test plan
All scenarios use STEP_DIV=4, F_STEP=8, AMP_MIN=256, KVF=32 (so amplitude = 256 + freq) unless noted.
1. Reset release, `start`=1, `target_freq`=2047 -> `pwm_en`=1 one cycle later with `amplitude`=256. Frequency steps by 8 every 4th `lock`. RUN is reached after 256 ticks with `frequency`=2047 and `amplitude`=2303.
2. In RUN at 2047, raise `stop` -> RAMP_DOWN. `frequency` reaches 0 after 256 ticks. On that same edge: IDLE, `pwm_en`=0, `amplitude`=0.
3. `fault` pulsed mid-ramp at `frequency`=400 -> the next edge gives FAULT, `pwm_en`=0, `frequency`=0. `start`=1 alone leaves the block in FAULT. `stop`=1 with `fault`=0 -> IDLE.
4. In RUN at 1000, change `target_freq` to 996 -> RAMP. After one tick `frequency`=996 (clamped step of 4), then RUN. No overshoot.
5. Set KVF=64 and target 2047 -> `amplitude` saturates at 4095 once `frequency` ≥ 1920 and never wraps.
6. Assert `rst_n`=0 at `frequency`=512 -> all outputs go to 0 asynchronously. After release the block stays in IDLE until `start` is asserted.
